// File: rtl/rggen_register_access_driver_pkg.sv
// Shared definitions for the register access driver: FSM encodings and the
// byte-address alignment helper.
package rggen_register_access_driver_pkg;

    localparam logic [1:0] STATE_IDLE     = 2'b00;
    localparam logic [1:0] STATE_ACCESS   = 2'b01;
    localparam logic [1:0] STATE_RESPONSE = 2'b10;

    // Number of low address bits that select a byte within one data word.
    function automatic int address_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rggen_strobe_to_mask.sv
// Combinational byte-strobe to bit-mask expander, shared by the bus bridges.
module rggen_strobe_to_mask #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/8-1:0] i_strobe,
    output logic [DATA_WIDTH-1:0]   o_mask
);

    for (genvar g = 0; g < DATA_WIDTH / 8; g++) begin : g_byte
        assign o_mask[8*g+:8] = {8{i_strobe[g]}};
    end

endmodule

// File: rtl/rggen_register_access_driver.sv
// Register-side access driver: decodes one bus request against this register,
// strobes the bit fields for a single cycle and returns a registered response.
module rggen_register_access_driver
    import rggen_register_access_driver_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                     DATA_WIDTH     = 32,
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_request_valid,
    output logic                      o_request_ready,
    input  logic                      i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_request_address,
    input  logic [DATA_WIDTH-1:0]     i_request_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_request_strobe,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic                      o_response_hit,
    output logic                      o_response_error,
    output logic [DATA_WIDTH-1:0]     o_response_read_data,
    output logic                      o_bit_field_valid,
    output logic [DATA_WIDTH-1:0]     o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]     o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]     o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]     i_bit_field_read_data
);

    localparam int ADDR_SHIFT = address_shift(DATA_WIDTH);

    logic [1:0]            state_q,           state_d;
    logic                  request_ready_q,   request_ready_d;
    logic                  response_valid_q,  response_valid_d;
    logic                  hit_q,             hit_d;
    logic                  error_q,           error_d;
    logic [DATA_WIDTH-1:0] read_data_q,       read_data_d;
    logic                  bit_field_valid_q, bit_field_valid_d;
    logic [DATA_WIDTH-1:0] read_mask_q,       read_mask_d;
    logic [DATA_WIDTH-1:0] write_mask_q,      write_mask_d;
    logic [DATA_WIDTH-1:0] write_data_q,      write_data_d;

    logic                  request_hit_s;
    logic                  request_error_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] strobe_mask_s;

    rggen_strobe_to_mask #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strobe_to_mask (
        .i_strobe (i_request_strobe),
        .o_mask   (strobe_mask_s)
    );

    // Word-granular address decode; byte-offset bits inside the word are ignored.
    assign request_hit_s   = (i_request_address >> ADDR_SHIFT) == (OFFSET_ADDRESS >> ADDR_SHIFT);
    assign request_error_s = request_hit_s &
                             ((i_request_write & !WRITABLE) | (!i_request_write & !READABLE));
    assign accept_s        = i_request_valid & request_ready_q;

    // Next-state and next-output computation.
    always_comb begin
        state_d           = state_q;
        response_valid_d  = response_valid_q;
        hit_d             = hit_q;
        error_d           = error_q;
        read_data_d       = read_data_q;
        bit_field_valid_d = 1'b0;
        read_mask_d       = '0;
        write_mask_d      = '0;
        write_data_d      = write_data_q;

        case (state_q)
            STATE_IDLE: begin
                if (accept_s) begin
                    hit_d       = request_hit_s;
                    error_d     = request_error_s;
                    read_data_d = '0;
                    if (request_hit_s && !request_error_s) begin
                        state_d           = STATE_ACCESS;
                        bit_field_valid_d = 1'b1;
                        write_data_d      = i_request_write_data;
                        if (i_request_write) begin
                            write_mask_d = strobe_mask_s;
                        end else begin
                            read_mask_d  = {DATA_WIDTH{1'b1}};
                        end
                    end else begin
                        state_d          = STATE_RESPONSE;
                        response_valid_d = 1'b1;
                    end
                end else begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_ACCESS: begin
                // read_mask_q is zero on writes, so write responses return zero data.
                read_data_d      = i_bit_field_read_data & read_mask_q;
                response_valid_d = 1'b1;
                state_d          = STATE_RESPONSE;
            end
            STATE_RESPONSE: begin
                if (i_response_ready) begin
                    response_valid_d = 1'b0;
                    state_d          = STATE_IDLE;
                end else begin
                    state_d = STATE_RESPONSE;
                end
            end
            default: begin
                state_d          = STATE_IDLE;
                response_valid_d = 1'b0;
            end
        endcase

        request_ready_d = (state_d == STATE_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= STATE_IDLE;
            request_ready_q   <= 1'b1;
            response_valid_q  <= 1'b0;
            hit_q             <= 1'b0;
            error_q           <= 1'b0;
            read_data_q       <= '0;
            bit_field_valid_q <= 1'b0;
            read_mask_q       <= '0;
            write_mask_q      <= '0;
            write_data_q      <= '0;
        end else begin
            state_q           <= state_d;
            request_ready_q   <= request_ready_d;
            response_valid_q  <= response_valid_d;
            hit_q             <= hit_d;
            error_q           <= error_d;
            read_data_q       <= read_data_d;
            bit_field_valid_q <= bit_field_valid_d;
            read_mask_q       <= read_mask_d;
            write_mask_q      <= write_mask_d;
            write_data_q      <= write_data_d;
        end
    end

    assign o_request_ready        = request_ready_q;
    assign o_response_valid       = response_valid_q;
    assign o_response_hit         = hit_q;
    assign o_response_error       = error_q;
    assign o_response_read_data   = read_data_q;
    assign o_bit_field_valid      = bit_field_valid_q;
    assign o_bit_field_read_mask  = read_mask_q;
    assign o_bit_field_write_mask = write_mask_q;
    assign o_bit_field_write_data = write_data_q;

endmodule

// File: tb/tb_rggen_register_access_driver.sv
// Directed bench: a read/write register and a write-protected one, both at 0x10,
// checked against a scoreboard of expected responses.
module tb_rggen_register_access_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        sel;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        resp_ready;
    logic [31:0] bf_rdata;

    wire         valid_m = req_valid & ~sel;
    wire         valid_r = req_valid & sel;

    logic        m_ready, m_rvalid, m_hit, m_err, m_bfv;
    logic [31:0] m_rdata, m_rmask, m_wmask, m_wdata;
    logic        r_ready, r_rvalid, r_hit, r_err, r_bfv;
    logic [31:0] r_rdata, r_rmask, r_wmask, r_wdata;

    rggen_register_access_driver #(
        .ADDRESS_WIDTH (8), .OFFSET_ADDRESS (8'h10), .DATA_WIDTH (32),
        .READABLE (1'b1), .WRITABLE (1'b1)
    ) dut (
        .i_clk (clk), .i_rst (rst),
        .i_request_valid (valid_m), .o_request_ready (m_ready),
        .i_request_write (req_write), .i_request_address (req_addr),
        .i_request_write_data (req_wdata), .i_request_strobe (req_strb),
        .o_response_valid (m_rvalid), .i_response_ready (resp_ready),
        .o_response_hit (m_hit), .o_response_error (m_err),
        .o_response_read_data (m_rdata),
        .o_bit_field_valid (m_bfv), .o_bit_field_read_mask (m_rmask),
        .o_bit_field_write_mask (m_wmask), .o_bit_field_write_data (m_wdata),
        .i_bit_field_read_data (bf_rdata)
    );

    rggen_register_access_driver #(
        .ADDRESS_WIDTH (8), .OFFSET_ADDRESS (8'h10), .DATA_WIDTH (32),
        .READABLE (1'b1), .WRITABLE (1'b0)
    ) dut_ro (
        .i_clk (clk), .i_rst (rst),
        .i_request_valid (valid_r), .o_request_ready (r_ready),
        .i_request_write (req_write), .i_request_address (req_addr),
        .i_request_write_data (req_wdata), .i_request_strobe (req_strb),
        .o_response_valid (r_rvalid), .i_response_ready (resp_ready),
        .o_response_hit (r_hit), .o_response_error (r_err),
        .o_response_read_data (r_rdata),
        .o_bit_field_valid (r_bfv), .o_bit_field_read_mask (r_rmask),
        .o_bit_field_write_mask (r_wmask), .o_bit_field_write_data (r_wdata),
        .i_bit_field_read_data (bf_rdata)
    );

    wire         o_ready  = sel ? r_ready  : m_ready;
    wire         o_rvalid = sel ? r_rvalid : m_rvalid;
    wire         o_hit    = sel ? r_hit    : m_hit;
    wire         o_err    = sel ? r_err    : m_err;
    wire         o_bfv    = sel ? r_bfv    : m_bfv;
    wire [31:0]  o_rdata  = sel ? r_rdata  : m_rdata;
    wire [31:0]  o_rmask  = sel ? r_rmask  : m_rmask;
    wire [31:0]  o_wmask  = sel ? r_wmask  : m_wmask;
    wire [31:0]  o_wdata  = sel ? r_wdata  : m_wdata;

    typedef struct packed {
        logic        hit;
        logic        error;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hit"},   32'(o_hit), 32'(e.hit));
            chk({tag, "_error"}, 32'(o_err), 32'(e.error));
            chk({tag, "_rdata"}, o_rdata,    e.rdata);
        end else begin
            chk({tag, "_valid"}, 32'(o_rvalid), 32'd1);
        end
    endtask

    // One full transaction with response_ready held high; request fields are
    // scrambled right after acceptance to show they were captured at accept.
    task automatic do_req(input string tag, input logic s, input logic w,
                          input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic access, input logic [31:0] exp_rmask,
                          input logic [31:0] exp_wmask, input resp_t e);
        @(negedge clk);
        sel = s; req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = st;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_addr = a ^ 8'hFF; req_wdata = ~d; req_strb = ~st;
        chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
        if (access) begin
            chk({tag, "_bfv"},     32'(o_bfv),    32'd1);
            chk({tag, "_rmask"},   o_rmask,       exp_rmask);
            chk({tag, "_wmask"},   o_wmask,       exp_wmask);
            chk({tag, "_wdata"},   o_wdata,       d);
            chk({tag, "_rv_early"}, 32'(o_rvalid), 32'd0);
            @(negedge clk);
        end else begin
            chk({tag, "_no_bfv"},  32'(o_bfv),    32'd0);
        end
        chk({tag, "_rvalid"}, 32'(o_rvalid), 32'd1);
        check_resp(tag);
        chk({tag, "_bfv_off"},  32'(o_bfv),   32'd0);
        chk({tag, "_masks_off"}, o_rmask | o_wmask, 32'd0);
        @(negedge clk);
        chk({tag, "_rv_done"},  32'(o_rvalid), 32'd0);
        chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; sel = 1'b0; req_write = 1'b0; req_addr = 8'h00;
        req_wdata = 32'h0; req_strb = 4'h0; resp_ready = 1'b1; bf_rdata = 32'hA5A5_1234;

        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(m_ready),  32'd1);
        chk("rst_rvalid", 32'(m_rvalid), 32'd0);
        chk("rst_bfv",    32'(m_bfv),    32'd0);
        chk("rst_rmask",  m_rmask,       32'h0);
        chk("rst_wmask",  m_wmask,       32'h0);
        chk("rst_wdata",  m_wdata,       32'h0);
        chk("rst_rdata",  m_rdata,       32'h0);
        chk("rst_hit_err", {30'd0, m_hit, m_err}, 32'd0);
        chk("rst_ro_ready", 32'(r_ready), 32'd1);
        rst = 1'b0;

        do_req("rd_hit",   1'b0, 1'b0, 8'h12, 32'h0000_0000, 4'hF, 1'b1,
               32'hFFFF_FFFF, 32'h0, '{1'b1, 1'b0, 32'hA5A5_1234});
        do_req("wr_hit",   1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'b0101, 1'b1,
               32'h0, 32'h00FF_00FF, '{1'b1, 1'b0, 32'h0});
        do_req("wr_strb0", 1'b0, 1'b1, 8'h11, 32'hCAFE_F00D, 4'b0000, 1'b1,
               32'h0, 32'h0, '{1'b1, 1'b0, 32'h0});
        do_req("wr_full",  1'b0, 1'b1, 8'h13, 32'h1234_5678, 4'b1111, 1'b1,
               32'h0, 32'hFFFF_FFFF, '{1'b1, 1'b0, 32'h0});
        do_req("rd_miss",  1'b0, 1'b0, 8'h14, 32'h0, 4'hF, 1'b0,
               32'h0, 32'h0, '{1'b0, 1'b0, 32'h0});
        chk("miss_wdata_hold", m_wdata, 32'h1234_5678);
        do_req("wr_miss",  1'b0, 1'b1, 8'h0C, 32'h5555_AAAA, 4'hF, 1'b0,
               32'h0, 32'h0, '{1'b0, 1'b0, 32'h0});
        do_req("ro_wr_err", 1'b1, 1'b1, 8'h10, 32'h7777_7777, 4'hF, 1'b0,
               32'h0, 32'h0, '{1'b1, 1'b1, 32'h0});
        do_req("ro_rd",    1'b1, 1'b0, 8'h10, 32'h0, 4'hF, 1'b1,
               32'hFFFF_FFFF, 32'h0, '{1'b1, 1'b0, 32'hA5A5_1234});

        // Response backpressure with a second request held valid throughout.
        resp_ready = 1'b0;
        @(negedge clk);
        sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_strb = 4'hF;
        exp_q.push_back('{1'b1, 1'b0, 32'hA5A5_1234});
        @(negedge clk);
        req_write = 1'b1; req_addr = 8'h11; req_wdata = 32'h3C3C_5A5A; req_strb = 4'b1100;
        chk("bp_bfv", 32'(m_bfv), 32'd1);
        @(negedge clk);
        bf_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", 32'(m_rvalid), 32'd1);
            chk("bp_hit",    32'(m_hit),    32'd1);
            chk("bp_err",    32'(m_err),    32'd0);
            chk("bp_rdata",  m_rdata,       32'hA5A5_1234);
            chk("bp_ready",  32'(m_ready),  32'd0);
            chk("bp_no_bfv", 32'(m_bfv),    32'd0);
            @(negedge clk);
        end
        check_resp("bp_resp");
        resp_ready = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 32'h0});
        @(negedge clk);
        chk("bp_hs_rv",    32'(m_rvalid), 32'd0);
        chk("bp_hs_ready", 32'(m_ready),  32'd1);
        chk("bp_hs_nobfv", 32'(m_bfv),    32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2_bfv",   32'(m_bfv), 32'd1);
        chk("bp2_wmask", m_wmask,    32'hFFFF_0000);
        chk("bp2_rmask", m_rmask,    32'h0);
        chk("bp2_wdata", m_wdata,    32'h3C3C_5A5A);
        @(negedge clk);
        chk("bp2_rvalid", 32'(m_rvalid), 32'd1);
        check_resp("bp2_resp");
        @(negedge clk);
        chk("bp2_done", 32'(m_rvalid), 32'd0);

        // Reset while the bit-field strobe is active discards the transaction.
        bf_rdata = 32'hA5A5_1234;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsta_bfv", 32'(m_bfv), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsta_bfv_off", 32'(m_bfv),    32'd0);
        chk("rsta_ready",   32'(m_ready),  32'd1);
        chk("rsta_rmask",   m_rmask,       32'h0);
        chk("rsta_rdata",   m_rdata,       32'h0);
        chk("rsta_hit",     32'(m_hit),    32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rsta_no_resp", 32'(m_rvalid), 32'd0);
            @(negedge clk);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
